// File: rtl/rf_echo_monitor_if.sv
// Bus between an RF loopback source and the echo monitor: enable and gate
// line inward, echo window and per-sequence result outward.
interface rf_echo_monitor_if #(
  parameter int CNT_W = 20
);
  logic             en;
  logic             rf_in;
  logic             echo_gate;
  logic             result_valid;
  logic             seq_ok;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] pi2_width;
  logic [CNT_W-1:0] tau_width;
  logic [CNT_W-1:0] pi_width;

  modport master (
    output en, rf_in,
    input  echo_gate, result_valid, seq_ok, err_code,
           pi2_width, tau_width, pi_width
  );

  modport slave (
    input  en, rf_in,
    output echo_gate, result_valid, seq_ok, err_code,
           pi2_width, tau_width, pi_width
  );
endinterface

// File: rtl/rf_echo_monitor.sv
// Spin-echo receive monitor: measures pi/2 pulse, free-precession gap and
// pi pulse on the synchronized RF gate line, checks both pulse widths and
// opens an echo window centred tau cycles after the pi pulse.
module rf_echo_monitor #(
  parameter int PI2_CYCLES = 333,
  parameter int TOL        = 2,
  parameter int ECHO_W     = 8,
  parameter int CNT_W      = 20
) (
  input logic               clk,
  input logic               rst,
  rf_echo_monitor_if.slave  bus
);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   wide_t;   // one spare bit so tau+/-ECHO_W never wraps

  typedef enum logic [2:0] {
    IDLE, ARMED, P1, GAP, P2, ECHO
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_PI2  = 3'd1,
    ERR_PI   = 3'd2,
    ERR_GAP  = 3'd3,
    ERR_OVF  = 3'd4,
    ERR_ECHO = 3'd5
  } err_e;

  typedef struct packed {
    logic ok;
    err_e err;
  } res_t;

  localparam cnt_t  CMAX   = '1;
  localparam cnt_t  CONE   = cnt_t'(1);
  localparam wide_t WONE   = wide_t'(1);
  localparam wide_t P1_LO  = wide_t'(PI2_CYCLES - TOL);
  localparam wide_t P1_HI  = wide_t'(PI2_CYCLES + TOL);
  localparam wide_t P2_LO  = wide_t'(2*PI2_CYCLES - TOL);
  localparam wide_t P2_HI  = wide_t'(2*PI2_CYCLES + TOL);
  localparam wide_t EW     = wide_t'(ECHO_W);

  // sync_pipe[0..1] is the two-flop synchronizer, [2] is the one-cycle delay
  logic [2:0] sync_pipe;
  logic       rf_s, rf_d, rise, fall;

  state_e state, state_n;
  cnt_t   cnt, cnt_n;
  wide_t  e, e_n;
  cnt_t   pi2_q, tau_q, pi_q;
  res_t   res_q;
  logic   rv_q;

  logic   lat_pi2, lat_tau, lat_pi;
  logic   fin;
  err_e   fin_err;
  logic   gate;

  wide_t  cnt_x, tau_x, win_lo, win_hi;
  logic   pi2_bad, pi_bad, in_win;

  assign rf_s = sync_pipe[1];
  assign rf_d = sync_pipe[2];
  assign rise = rf_s & ~rf_d;
  assign fall = ~rf_s & rf_d;

  assign cnt_x   = wide_t'(cnt);
  assign tau_x   = wide_t'(tau_q);
  assign pi2_bad = (cnt_x < P1_LO) || (cnt_x > P1_HI);
  assign pi_bad  = (cnt_x < P2_LO) || (cnt_x > P2_HI);
  // window start clamps at 1 for short gaps
  assign win_lo  = (tau_x > EW) ? (tau_x - EW) : WONE;
  assign win_hi  = tau_x + EW;
  assign in_win  = (e >= win_lo) && (e <= win_hi);

  // Input synchronizer and edge-detect delay line
  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[1:0], bus.rf_in};
  end

  // Sequence state, duration counter and echo-phase counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      e     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      e     <= e_n;
    end
  end

  // Next-state, latch strobes and result decision
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    e_n     = e;
    lat_pi2 = 1'b0;
    lat_tau = 1'b0;
    lat_pi  = 1'b0;
    fin     = 1'b0;
    fin_err = ERR_NONE;
    gate    = 1'b0;
    if (!bus.en) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (!rf_s) state_n = ARMED;
        ARMED: if (rise) begin
          state_n = P1;
          cnt_n   = CONE;
        end
        P1: begin
          if (fall) begin
            lat_pi2 = 1'b1;
            if (pi2_bad) begin
              fin = 1'b1; fin_err = ERR_PI2; state_n = IDLE;
            end else begin
              state_n = GAP; cnt_n = CONE;
            end
          end else if (cnt == CMAX) begin
            fin = 1'b1; fin_err = ERR_OVF; state_n = IDLE;
          end else begin
            cnt_n = cnt + CONE;
          end
        end
        GAP: begin
          if (rise) begin
            lat_tau = 1'b1; state_n = P2; cnt_n = CONE;
          end else if (cnt == CMAX) begin
            fin = 1'b1; fin_err = ERR_GAP; state_n = IDLE;
          end else begin
            cnt_n = cnt + CONE;
          end
        end
        P2: begin
          if (fall) begin
            lat_pi = 1'b1;
            if (pi_bad) begin
              fin = 1'b1; fin_err = ERR_PI; state_n = IDLE;
            end else begin
              state_n = ECHO; e_n = WONE;
            end
          end else if (cnt == CMAX) begin
            fin = 1'b1; fin_err = ERR_OVF; state_n = IDLE;
          end else begin
            cnt_n = cnt + CONE;
          end
        end
        ECHO: begin
          // a new pulse inside the echo phase kills the window immediately
          if (rise) begin
            fin = 1'b1; fin_err = ERR_ECHO; state_n = IDLE;
          end else begin
            gate = in_win;
            if (e == win_hi) begin
              fin = 1'b1; state_n = ARMED;
            end else begin
              e_n = e + WONE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Width latches and result registers (result fields hold until next strobe)
  always_ff @(posedge clk) begin
    if (rst) begin
      pi2_q <= '0;
      tau_q <= '0;
      pi_q  <= '0;
      res_q <= '{ok: 1'b0, err: ERR_NONE};
      rv_q  <= 1'b0;
    end else begin
      if (lat_pi2) pi2_q <= cnt;
      if (lat_tau) tau_q <= cnt;
      if (lat_pi)  pi_q  <= cnt;
      rv_q <= fin;
      if (fin) res_q <= '{ok: (fin_err == ERR_NONE), err: fin_err};
    end
  end

  assign bus.echo_gate    = gate;
  assign bus.result_valid = rv_q;
  assign bus.seq_ok       = res_q.ok;
  assign bus.err_code     = res_q.err;
  assign bus.pi2_width    = pi2_q;
  assign bus.tau_width    = tau_q;
  assign bus.pi_width     = pi_q;

endmodule
